stop_frame_check: RTL and testbench

- Parametrised sequential stop-bit checker for the UART receive path.
- Sits between the RX sampler, which supplies the sampled bit and its strobe, and the RX control FSM, which marks the start of the stop phase.
- Checks 1..NUM_STOP_MAX stop bits per frame and reports one registered per-frame verdict.
- Keeps a sticky error flag; optionally keeps a saturating error counter for status.

---
 rtl/uart_rx_pkg.sv | 19 +
 rtl/stop_frame_check.sv | 146 ++++++++++++++
 tb/tb_stop_frame_check.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART RX definitions: stop-checker states and stop-bit polarity constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    REPORT = 2'd2
  } stop_chk_state_e;

  // Idle/stop level of the RX line.
  localparam logic STOP_BIT = 1'b1;

  // Per-frame verdict encodings.
  localparam logic STP_ERR = 1'b1;
  localparam logic STP_OK  = 1'b0;

endpackage

// File: rtl/stop_frame_check.sv
// Stop-bit checker: verifies 1..NUM_STOP_MAX stop samples per frame, registered verdict, sticky flag; err_cnt only with STOP_ERR_CNT_EN.
// Latency: frame_done/stp_err rise one cycle after the edge that captures the last stop sample.
// Backpressure: none; samples are taken whenever sample_vld is high in CHECK, chk_start always wins.
module stop_frame_check
  import uart_rx_pkg::*;
#(
  parameter int NUM_STOP_MAX = 2,
  parameter int CNT_W        = 8,
  parameter int IDX_W        = $clog2(NUM_STOP_MAX + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             chk_start,
  input  logic [IDX_W-1:0] stop_num,
  input  logic             sample_vld,
  input  logic             sampled_bit,
  input  logic             err_clr,
  output logic             busy,
  output logic             frame_done,
  output logic             stp_err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_STOP_MAX);

  stop_chk_state_e  state_q, state_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [IDX_W-1:0] target_q, target_d;
  logic             acc_q, acc_d;
  logic             frame_done_q, frame_done_d;
  logic             stp_err_q, stp_err_d;
  logic             err_sticky_q, err_sticky_d;
  logic [IDX_W-1:0] stop_num_clamped;
  logic             in_report;
  logic             report_err;

  assign in_report  = (state_q == REPORT);
  assign report_err = in_report && (acc_q == STP_ERR);

  // Requested stop count forced into 1..NUM_STOP_MAX.
  always_comb begin
    stop_num_clamped = stop_num;
    if (stop_num == '0) begin
      stop_num_clamped = IDX_ONE;
    end else if (stop_num > IDX_MAX) begin
      stop_num_clamped = IDX_MAX;
    end
  end

  // Frame sequencing: a new chk_start always restarts, otherwise count samples to target.
  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    target_d = target_q;
    acc_d    = acc_q;
    if (chk_start) begin
      // Any state: begin (or restart) a frame; a coincident sample is dropped.
      state_d  = CHECK;
      index_d  = '0;
      acc_d    = STP_OK;
      target_d = stop_num_clamped;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        CHECK: begin
          if (sample_vld) begin
            acc_d   = acc_q | (sampled_bit != STOP_BIT);
            index_d = index_q + IDX_ONE;
            if (index_d == target_q) begin
              state_d = REPORT;
            end
          end
        end
        REPORT: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Verdict and sticky flag, both updated on the edge leaving REPORT; set beats clear.
  always_comb begin
    frame_done_d = in_report;
    stp_err_d    = in_report ? acc_q : stp_err_q;
    err_sticky_d = (err_sticky_q & ~err_clr) | report_err;
  end

  // State and status registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      index_q      <= '0;
      target_q     <= '0;
      acc_q        <= STP_OK;
      frame_done_q <= 1'b0;
      stp_err_q    <= STP_OK;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      target_q     <= target_d;
      acc_q        <= acc_d;
      frame_done_q <= frame_done_d;
      stp_err_q    <= stp_err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

`ifdef STOP_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Saturating error-frame counter: clear first, then count this frame's error.
  always_comb begin
    err_cnt_d = err_clr ? '0 : err_cnt_q;
    if (report_err && (err_cnt_d != '1)) begin
      err_cnt_d = err_cnt_d + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

  assign busy       = (state_q == CHECK);
  assign frame_done = frame_done_q;
  assign stp_err    = stp_err_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_stop_frame_check.sv
// Directed bench for stop_frame_check (NUM_STOP_MAX=2, CNT_W=2); verdicts scored through a queue.
// Latency: checks frame_done one cycle after the last sample edge.
// Backpressure: n/a.
module tb_stop_frame_check;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       chk_start = 1'b0;
  logic [1:0] stop_num = 2'd0;
  logic       sample_vld = 1'b0;
  logic       sampled_bit = 1'b0;
  logic       err_clr = 1'b0;
  logic       busy;
  logic       frame_done;
  logic       stp_err;
  logic       err_sticky;
  logic [1:0] err_cnt;

  stop_frame_check #(
    .NUM_STOP_MAX(2),
    .CNT_W       (2)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .chk_start  (chk_start),
    .stop_num   (stop_num),
    .sample_vld (sample_vld),
    .sampled_bit(sampled_bit),
    .err_clr    (err_clr),
    .busy       (busy),
    .frame_done (frame_done),
    .stp_err    (stp_err),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       stp;
    logic       stk;
    logic [1:0] cnt;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_err = 0;
  logic       m_acc = 1'b0;
  logic       m_sticky = 1'b0;
  logic [1:0] m_cnt = 2'd0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Start a frame; optionally with a coincident sample that must be dropped.
  task automatic start(input logic [1:0] n, input logic with_smp, input logic b);
    chk_start   = 1'b1;
    stop_num    = n;
    sample_vld  = with_smp;
    sampled_bit = b;
    m_acc       = 1'b0;
    tick();
    chk_start  = 1'b0;
    sample_vld = 1'b0;
  endtask

  task automatic samp(input logic b);
    sample_vld  = 1'b1;
    sampled_bit = b;
    m_acc       = m_acc | (b != 1'b1);
    tick();
    sample_vld = 1'b0;
  endtask

  // Called in the REPORT cycle: predict verdict, optionally clear/restart, check latency.
  task automatic report(input logic clr, input logic st, input logic [1:0] n);
    exp_t e;
    m_sticky = (m_sticky & ~clr) | m_acc;
`ifdef STOP_ERR_CNT_EN
    if (clr) m_cnt = 2'd0;
    if (m_acc && m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
`endif
    e.stp = m_acc;
    e.stk = m_sticky;
    e.cnt = m_cnt;
    exp_q.push_back(e);
    chk("done_not_early", frame_done, 0);
    chk("busy_in_report", busy, 0);
    err_clr   = clr;
    chk_start = st;
    stop_num  = n;
    if (st) m_acc = 1'b0;
    tick();
    err_clr   = 1'b0;
    chk_start = 1'b0;
    chk("done_latency", frame_done, 1);
    chk("busy_after_report", busy, st);
  endtask

  // Scoreboard: every frame_done pulse must match the oldest predicted verdict.
  always begin
    exp_t e;
    @(posedge CLK);
    #2;
    if (frame_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", frame_done, 0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_stp_err", stp_err, e.stp);
        chk("sb_sticky", err_sticky, e.stk);
        chk("sb_err_cnt", err_cnt, e.cnt);
      end
    end
  end

  initial begin
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_stp_err", stp_err, 0);
    chk("rst_sticky", err_sticky, 0);
    chk("rst_cnt", err_cnt, 0);
    @(negedge CLK);
    RST = 1'b1;
    tick();

    // Samples in IDLE do nothing.
    samp(1'b0);
    samp(1'b0);
    chk("idle_busy", busy, 0);
    m_acc = 1'b0;

    // One stop bit, good.
    start(2'd1, 1'b0, 1'b0);
    chk("busy_check", busy, 1);
    samp(1'b1);
    report(1'b0, 1'b0, 2'd0);

    // Two stop bits, second bad.
    start(2'd2, 1'b0, 1'b0);
    samp(1'b1);
    chk("busy_mid", busy, 1);
    samp(1'b0);
    report(1'b0, 1'b0, 2'd0);

    // Two good stop bits; sticky stays set.
    start(2'd2, 1'b0, 1'b0);
    samp(1'b1);
    samp(1'b1);
    report(1'b0, 1'b0, 2'd0);

    // stop_num=0 behaves as one.
    start(2'd0, 1'b0, 1'b0);
    samp(1'b0);
    report(1'b0, 1'b0, 2'd0);

    // stop_num=3 clamps to two.
    start(2'd3, 1'b0, 1'b0);
    samp(1'b1);
    chk("clamp_busy", busy, 1);
    samp(1'b1);
    report(1'b0, 1'b0, 2'd0);

    // Abort after one bad sample; restart drops its coincident sample.
    start(2'd2, 1'b0, 1'b0);
    samp(1'b0);
    start(2'd2, 1'b1, 1'b0);
    samp(1'b1);
    chk("abort_busy", busy, 1);
    samp(1'b1);
    report(1'b0, 1'b0, 2'd0);

    // chk_start during REPORT starts the next frame immediately.
    start(2'd1, 1'b0, 1'b0);
    samp(1'b0);
    report(1'b0, 1'b1, 2'd1);
    samp(1'b1);
    report(1'b0, 1'b0, 2'd0);

    // Five error frames: counter saturates.
    for (int i = 0; i < 5; i++) begin
      start(2'd1, 1'b0, 1'b0);
      samp(1'b0);
      report(1'b0, 1'b0, 2'd0);
    end
    tick();
    chk("sat_cnt", err_cnt, m_cnt);

    // Clear coincident with an error report: set wins, count restarts at one.
    start(2'd1, 1'b0, 1'b0);
    samp(1'b0);
    report(1'b1, 1'b0, 2'd0);

    // Clear alone.
    err_clr = 1'b1;
    tick();
    err_clr  = 1'b0;
    m_sticky = 1'b0;
    m_cnt    = 2'd0;
    chk("clr_sticky", err_sticky, 0);
    chk("clr_cnt", err_cnt, 0);
    chk("clr_stp_hold", stp_err, 1);

    // Error frame, then asynchronous reset in the middle of CHECK.
    start(2'd1, 1'b0, 1'b0);
    samp(1'b0);
    report(1'b0, 1'b0, 2'd0);
    start(2'd2, 1'b0, 1'b0);
    samp(1'b1);
    #3;
    RST = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", frame_done, 0);
    chk("arst_stp_err", stp_err, 0);
    chk("arst_sticky", err_sticky, 0);
    chk("arst_cnt", err_cnt, 0);
    m_sticky = 1'b0;
    m_cnt    = 2'd0;
    m_acc    = 1'b0;
    #2;
    RST = 1'b1;
    tick();
    // Back in IDLE: a lone sample must not complete the interrupted frame.
    samp(1'b1);
    chk("post_rst_busy", busy, 0);
    tick();
    tick();
    chk("queue_drained", 8'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
